// File: rtl/usb3_rx_align_descram.sv
// USB 3.0 RX symbol aligner/descrambler: strips SKP symbols, repacks into full beats, descrambles D-symbols.
// Latency: 3 cycles for a SKP-free stream (compact reg, accumulator, output reg); SKP removal adds latency.
// Backpressure: none; every out_valid beat must be accepted by the consumer.
//
// Ports:
//   local_clk, reset_n      : clock, async active-low reset
//   enable                  : 1 = descramble D-symbols, 0 = pass through with LFSR parked at seed
//   in_valid/in_datak/in_data    : PIPE RX beat, byte 0 earliest on the wire
//   out_valid/out_datak/out_data : repacked, descrambled beat
//   out_locked              : sticky, set by the first COM after reset
//   skp_count               : saturating count of removed SKP symbols
module usb3_rx_align_descram #(
  parameter int unsigned NSYM      = 4,
  parameter logic [7:0]  SKP_CODE  = 8'h3C,
  parameter logic [7:0]  COM_CODE  = 8'hBC,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic              local_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [NSYM-1:0]   in_datak,
  input  logic [8*NSYM-1:0] in_data,
  output logic              out_valid,
  output logic [NSYM-1:0]   out_datak,
  output logic [8*NSYM-1:0] out_data,
  output logic              out_locked,
  output logic [15:0]       skp_count
);

  // Depth/count width; PW slots is a power of two so DW-bit indices always land in range.
  localparam int unsigned DW = $clog2(2 * NSYM);
  localparam int unsigned PW = 2 ** DW;

  typedef logic [8:0] sym_t;  // {k flag, byte}

  // Advance the Galois LFSR by 8 shifts; returns {next state, scramble byte}.
  // Scramble bit k is taken from bit 15 before the k-th shift.
  function automatic logic [23:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0]  b;
    l = s;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      b[k] = l[15];
      l    = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
    end
    return {l, b};
  endfunction

  // ---------------- stage 1: compact ----------------
  sym_t           w_pk [PW];
  logic [DW-1:0]  w_n;
  logic [DW-1:0]  w_nskp;
  logic [16:0]    w_skp_sum;
  sym_t           r_pk [NSYM];
  logic [DW-1:0]  r_n;

  always_comb begin
    for (int j = 0; j < PW; j++) w_pk[j] = '0;
    w_n    = '0;
    w_nskp = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (in_datak[i] && (in_data[8*i +: 8] == SKP_CODE)) begin
        w_nskp = w_nskp + DW'(1);
      end else begin
        w_pk[w_n] = {in_datak[i], in_data[8*i +: 8]};
        w_n       = w_n + DW'(1);
      end
    end
    w_skp_sum = {1'b0, skp_count} + 17'(w_nskp);
  end

  // ---------------- stage 2: accumulate ----------------
  sym_t           r_acc [PW];
  sym_t           w_acc_nxt [PW];
  logic [DW-1:0]  r_d;
  logic [DW-1:0]  w_base;
  logic [DW-1:0]  w_d_nxt;
  logic           w_emit;

  always_comb begin
    w_emit = (r_d >= DW'(NSYM));
    w_base = w_emit ? (r_d - DW'(NSYM)) : r_d;
    // Drop the emitted beat from the head, then append the new symbols behind the survivors.
    for (int j = 0; j < PW; j++) begin
      if (!w_emit)            w_acc_nxt[j] = r_acc[j];
      else if (j + NSYM < PW) w_acc_nxt[j] = r_acc[j + NSYM];
      else                    w_acc_nxt[j] = '0;
    end
    for (int i = 0; i < NSYM; i++) begin
      if (DW'(i) < r_n) w_acc_nxt[w_base + DW'(i)] = r_pk[i];
    end
    w_d_nxt = w_base + r_n;
  end

  // ---------------- stage 3: descramble ----------------
  logic [15:0]       r_lfsr;
  logic [15:0]       w_lfsr;
  logic [23:0]       w_step;
  sym_t              w_sym;
  logic              w_com;
  logic [8*NSYM-1:0] w_od;
  logic [NSYM-1:0]   w_ok;

  always_comb begin
    w_lfsr = r_lfsr;
    w_step = '0;
    w_sym  = '0;
    w_com  = 1'b0;
    w_od   = '0;
    w_ok   = '0;
    for (int i = 0; i < NSYM; i++) begin
      w_sym   = r_acc[i];
      w_step  = lfsr_step8(w_lfsr);
      w_ok[i] = w_sym[8];
      if (w_sym[8] && (w_sym[7:0] == COM_CODE)) begin
        w_od[8*i +: 8] = w_sym[7:0];
        w_lfsr         = LFSR_SEED;
        w_com          = 1'b1;
      end else if (w_sym[8]) begin
        w_od[8*i +: 8] = w_sym[7:0];
        w_lfsr         = w_step[23:8];
      end else begin
        w_od[8*i +: 8] = w_sym[7:0] ^ (enable ? w_step[7:0] : 8'h00);
        w_lfsr         = w_step[23:8];
      end
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n <= '0;
      for (int i = 0; i < NSYM; i++) r_pk[i] <= '0;
      r_d <= '0;
      for (int j = 0; j < PW; j++) r_acc[j] <= '0;
      r_lfsr     <= LFSR_SEED;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_datak  <= '0;
      out_locked <= 1'b0;
      skp_count  <= '0;
    end else begin
      r_n <= in_valid ? w_n : '0;
      for (int i = 0; i < NSYM; i++) r_pk[i] <= w_pk[i];
      if (in_valid) skp_count <= w_skp_sum[16] ? 16'hFFFF : w_skp_sum[15:0];
      r_d   <= w_d_nxt;
      r_acc <= w_acc_nxt;
      out_valid <= w_emit;
      if (w_emit) begin
        out_data  <= w_od;
        out_datak <= w_ok;
        if (w_com) out_locked <= 1'b1;
      end
      // The LFSR only moves with emitted beats; with descrambling off it is parked at the seed.
      if (!enable)     r_lfsr <= LFSR_SEED;
      else if (w_emit) r_lfsr <= w_lfsr;
    end
  end

endmodule

// File: tb/tb_usb3_rx_align_descram.sv
module tb_usb3_rx_align_descram;
  localparam int         N   = 4;
  localparam logic [7:0] SKP = 8'h3C;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] KOT = 8'hF7;

  logic        local_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        in_valid;
  logic [3:0]  in_datak;
  logic [31:0] in_data;
  logic        out_valid;
  logic [3:0]  out_datak;
  logic [31:0] out_data;
  logic        out_locked;
  logic [15:0] skp_count;

  usb3_rx_align_descram #(.NSYM(N)) dut (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_datak  (in_datak),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_datak (out_datak),
    .out_data  (out_data),
    .out_locked(out_locked),
    .skp_count (skp_count)
  );

  always #5 local_clk = ~local_clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_beats = 0;

  // ---------------- reference model ----------------
  // Stream view: non-SKP symbols queue up; every N of them form one output beat.
  // Descrambling uses the symbol position since the last COM to index the scramble sequence.
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        lock;
  } beat_t;

  logic [7:0] scr_tab [4096];
  logic [8:0] sym_q [$];
  beat_t      exp_q [$];
  int         m_pos;
  logic       m_lock;
  int         m_skp;
  beat_t      cmp_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic build_tab();
    logic [15:0] l;
    logic [7:0]  b;
    l = 16'hFFFF;
    for (int p = 0; p < 4096; p++) begin
      b = '0;
      for (int k = 0; k < 8; k++) begin
        b[k] = l[15];
        l = l[15] ? ((l << 1) ^ 16'h0039) : (l << 1);
      end
      scr_tab[p] = b;
    end
  endtask

  task automatic model_reset();
    sym_q.delete();
    exp_q.delete();
    m_pos  = 0;
    m_lock = 1'b0;
    m_skp  = 0;
  endtask

  task automatic model_beat(input logic [3:0] k, input logic [31:0] d);
    beat_t      b;
    logic [8:0] s;
    for (int i = 0; i < N; i++) begin
      if (k[i] && d[8*i +: 8] == SKP) m_skp = (m_skp < 65535) ? m_skp + 1 : 65535;
      else sym_q.push_back({k[i], d[8*i +: 8]});
    end
    while (sym_q.size() >= N) begin
      b = '0;
      for (int i = 0; i < N; i++) begin
        s = sym_q.pop_front();
        b.k[i] = s[8];
        if (s[8] && s[7:0] == COM) begin
          b.d[8*i +: 8] = s[7:0];
          m_pos  = 0;
          m_lock = 1'b1;
        end else if (s[8] || !enable) begin
          b.d[8*i +: 8] = s[7:0];
          m_pos++;
        end else begin
          b.d[8*i +: 8] = s[7:0] ^ scr_tab[m_pos];
          m_pos++;
        end
      end
      if (!enable) m_pos = 0;
      b.lock = m_lock;
      exp_q.push_back(b);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] k, input logic [31:0] d);
    in_valid = 1'b1;
    in_datak = k;
    in_data  = d;
    model_beat(k, d);
    @(posedge local_clk); #1;
  endtask

  // Idle beats carry SKP garbage that must be ignored.
  task automatic idle(input int n);
    in_valid = 1'b0;
    in_datak = 4'hF;
    in_data  = {4{SKP}};
    repeat (n) begin @(posedge local_clk); #1; end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
    @(posedge local_clk); #1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge local_clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got data %h k %h, expected no beat at %0t", out_data, out_datak, $time);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("beat_data", out_data, cmp_e.d);
        chk("beat_k", 32'(out_datak), 32'(cmp_e.k));
        chk("beat_lock", 32'(out_locked), 32'(cmp_e.lock));
        n_beats++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int         beats0;
  logic [3:0] rk;
  logic [31:0] rd;
  int         r;

  initial begin
    build_tab();
    chk("scr0", 32'(scr_tab[0]), 32'hFF);
    chk("scr1", 32'(scr_tab[1]), 32'h17);
    chk("scr2", 32'(scr_tab[2]), 32'hC0);
    chk("scr3", 32'(scr_tab[3]), 32'h14);
    chk("scr4", 32'(scr_tab[4]), 32'hB2);
    chk("scr5", 32'(scr_tab[5]), 32'hE7);
    chk("scr6", 32'(scr_tab[6]), 32'h02);
    chk("scr7", 32'(scr_tab[7]), 32'h82);

    reset_n  = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_datak = '0;
    in_data  = '0;
    model_reset();
    repeat (3) @(posedge local_clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_k", 32'(out_datak), 32'h0);
    chk("rst_lock", 32'(out_locked), 32'h0);
    chk("rst_skp", 32'(skp_count), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // Scrambled zeros, latency and lock.
    send(4'hF, {4{COM}});
    send(4'h0, 32'h14C017FF);
    chk("s1_not_early", 32'(out_valid), 32'h0);
    chk("s1_lock_before", 32'(out_locked), 32'h0);
    send(4'h0, 32'h8202E7B2);
    chk("s1_valid_t3", 32'(out_valid), 32'h1);
    chk("s1_com_data", out_data, 32'hBCBCBCBC);
    chk("s1_com_k", 32'(out_datak), 32'hF);
    chk("s1_lock", 32'(out_locked), 32'h1);
    idle(1);
    chk("s1_zero0", out_data, 32'h0);
    chk("s1_zero0_k", 32'(out_datak), 32'h0);
    idle(1);
    chk("s1_zero1", out_data, 32'h0);
    idle(3);
    chk("s1_hold", out_data, 32'h0);
    chk("s1_drain", 32'(exp_q.size()), 32'h0);

    // SKP removal with masks 0001, 0110, 1010, 1111.
    do_reset();
    beats0 = n_beats;
    send(4'hF, {4{COM}});
    send(4'b0001, 32'hC017FF3C);
    send(4'b0110, 32'hB23C3C14);
    send(4'b1010, 32'h3C023CE7);
    send(4'b1111, 32'h3C3C3C3C);
    chk("s2_skp9", 32'(skp_count), 32'd9);
    send(4'b0000, {scr_tab[10], scr_tab[9], scr_tab[8], 8'h82});
    idle(6);
    chk("s2_beats", 32'(n_beats - beats0), 32'd3);
    chk("s2_last_zero", out_data, 32'h0);
    chk("s2_skp_hold", 32'(skp_count), 32'd9);
    chk("s2_drain", 32'(exp_q.size()), 32'h0);

    // COM in the middle of a beat.
    do_reset();
    send(4'b0011, 32'h17FFBCBC);
    send(4'b0000, 32'hE7B214C0);
    send(4'b0100, 32'hFFBC8202);
    idle(2);
    chk("s3_mid_com", out_data, 32'h00BC0000);
    chk("s3_mid_com_k", 32'(out_datak), 32'h4);
    idle(3);

    // Descrambling disabled: raw pass-through.
    do_reset();
    enable = 1'b0;
    send(4'hF, {4{COM}});
    send(4'h0, 32'h14C017FF);
    send(4'h0, 32'h8202E7B2);
    chk("s4_com", out_data, 32'hBCBCBCBC);
    idle(1);
    chk("s4_raw0", out_data, 32'h14C017FF);
    idle(1);
    chk("s4_raw1", out_data, 32'h8202E7B2);
    chk("s4_lock", 32'(out_locked), 32'h1);
    idle(3);
    enable = 1'b1;
    send(4'h0, 32'h14C017FF);
    idle(2);
    chk("s4_seed_held", out_data, 32'h0);
    idle(3);

    // Random gaps and symbol mix.
    do_reset();
    send(4'hF, {4{COM}});
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        for (int i = 0; i < N; i++) begin
          r = $urandom_range(0, 99);
          if (r < 20)      begin rk[i] = 1'b1; rd[8*i +: 8] = SKP; end
          else if (r < 25) begin rk[i] = 1'b1; rd[8*i +: 8] = COM; end
          else if (r < 30) begin rk[i] = 1'b1; rd[8*i +: 8] = KOT; end
          else             begin rk[i] = 1'b0; rd[8*i +: 8] = 8'($urandom); end
        end
        send(rk, rd);
      end
    end
    idle(6);
    chk("s5_drain", 32'(exp_q.size()), 32'h0);
    chk("s5_skp", 32'(skp_count), 32'(m_skp));

    // Async reset with 3 symbols parked in the accumulator.
    do_reset();
    send(4'hF, {4{COM}});
    send(4'b0001, 32'hC017FF3C);
    idle(1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_data", out_data, 32'h0);
    chk("ar_k", 32'(out_datak), 32'h0);
    chk("ar_lock", 32'(out_locked), 32'h0);
    chk("ar_skp", 32'(skp_count), 32'h0);
    #3;
    reset_n = 1'b1;
    @(posedge local_clk); #1;
    send(4'h0, 32'h44332211);
    idle(2);
    chk("ar_post_valid", 32'(out_valid), 32'h1);
    chk("ar_post_data", out_data, 32'h50F335EE);
    chk("ar_post_lock", 32'(out_locked), 32'h0);
    idle(3);

    // skp_count saturation.
    do_reset();
    repeat (16383) send(4'hF, {4{SKP}});
    send(4'b0011, 32'h12343C3C);
    chk("sat_fffe", 32'(skp_count), 32'hFFFE);
    send(4'hF, {4{SKP}});
    chk("sat_ffff", 32'(skp_count), 32'hFFFF);
    send(4'hF, {4{SKP}});
    chk("sat_hold", 32'(skp_count), 32'hFFFF);
    idle(4);
    chk("sat_no_beat", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
